// File: rtl/dpsram_rr_arb.sv
// Round-robin arbiter for port 0 of a dual-port SRAM shared by R requesters.
// Grants that would collide with the external port-1 access are suppressed and counted.
module dpsram_rr_arb #(
  parameter int unsigned R  = 4,
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 128,
  parameter int unsigned CW = 16,
  localparam int unsigned A  = $clog2(N),
  localparam int unsigned IW = $clog2(R)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req_valid,
  input  logic [R-1:0]      req_wen,
  input  logic [R*A-1:0]    req_addr,
  input  logic [R*W-1:0]    req_wdata,
  output logic [R-1:0]      req_ready,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_rdata,
  output logic              sram_en,
  output logic              sram_wen,
  output logic [A-1:0]      sram_addr,
  output logic [W-1:0]      sram_din,
  input  logic [W-1:0]      sram_dout,
  input  logic              p1_en,
  input  logic              p1_wen,
  input  logic [A-1:0]      p1_addr,
  output logic [CW-1:0]     coll_cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] c);
    return IW'((int'(c) + 1) % int'(R));
  endfunction

  logic [IW-1:0] r_ptr;
  logic          r_rsp_vld_p1;
  logic [IW-1:0] r_rsp_id_p1;
  logic [CW-1:0] r_coll_cnt;

  logic          w_found;
  logic [IW-1:0] w_cand;
  int            w_idx;
  logic          w_c_wen;
  logic [A-1:0]  w_c_addr;
  logic [W-1:0]  w_c_wdata;
  logic          w_coll;
  logic          w_grant;

  // Stage p0: combinational candidate search starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = 0;
    for (int k = 0; k < int'(R); k++) begin
      w_idx = (int'(r_ptr) + k) % int'(R);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_cand  = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_c_wen   = req_wen[w_cand];
    w_c_addr  = req_addr[int'(w_cand)*int'(A) +: A];
    w_c_wdata = req_wdata[int'(w_cand)*int'(W) +: W];
    // Same-address access on both ports is only harmless when both are reads.
    w_coll    = w_found && p1_en && (p1_addr == w_c_addr) && (p1_wen || w_c_wen);
    w_grant   = w_found && !w_coll;
  end

  always_comb begin
    req_ready = '0;
    sram_en   = 1'b0;
    sram_wen  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (w_grant) begin
      req_ready[w_cand] = 1'b1;
      sram_en   = 1'b1;
      sram_wen  = w_c_wen;
      sram_addr = w_c_addr;
      sram_din  = w_c_wdata;
    end
  end

  // Stage p1: response tag aligned with the SRAM's registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_rsp_vld_p1 <= 1'b0;
      r_rsp_id_p1  <= '0;
      r_coll_cnt   <= '0;
    end else begin
      r_rsp_vld_p1 <= w_grant && !w_c_wen;
      if (w_grant) begin
        r_ptr <= ptr_next(w_cand);
        if (!w_c_wen) r_rsp_id_p1 <= w_cand;
      end
      if (w_coll) r_coll_cnt <= sat_inc(r_coll_cnt);
    end
  end

  assign rsp_valid = r_rsp_vld_p1;
  assign rsp_id    = r_rsp_id_p1;
  assign rsp_rdata = sram_dout;
  assign coll_cnt  = r_coll_cnt;

endmodule
